// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits, LSB first, one stop bit (8N1).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end       = (cnt_q == CNT_LAST);
    assign data_in_ready = (state_q == ST_IDLE);
    assign serial_out    = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (data_in_valid) begin
                    shift_d = data_in;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Rotate rather than shift: after 8 bits the byte is intact again for parity.
                    shift_d = {shift_q[0], shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Line level is decoded from the next state so the registered output lines up with it.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = ^shift_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: 10 cycles/bit instance plus a default-rate instance.
// Frame expectations follow UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic [7:0] data_def = 8'h00;
    logic       valid_def = 1'b0;
    logic       ready_def;
    logic       so_def;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .serial_out(serial_out)
    );

    uart_transmitter dut_def (
        .clk(clk), .rst(rst), .data_in(data_def), .data_in_valid(valid_def),
        .data_in_ready(ready_def), .serial_out(so_def)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called in the first START cycle (#1 after the handshake edge); returns in the first IDLE cycle.
    task automatic check_frame(input string tag, input logic [7:0] d, input bit use_def, input int per);
        logic exp_b, obs_b, s, r, bad_rdy;
        for (int b = 0; b < NBITS; b++) begin
            exp_b   = frame_bit(d, b);
            obs_b   = exp_b;
            bad_rdy = 1'b0;
            for (int c = 0; c < per; c++) begin
                s = use_def ? so_def : serial_out;
                r = use_def ? ready_def : data_in_ready;
                if (s !== exp_b) obs_b = s;
                if (r !== 1'b0) bad_rdy = 1'b1;
                @(posedge clk); #1;
            end
            chk($sformatf("%s bit%0d level", tag, b), {31'd0, obs_b}, {31'd0, exp_b});
            chk($sformatf("%s bit%0d ready_low", tag, b), {31'd0, bad_rdy}, 32'd0);
        end
        r = use_def ? ready_def : data_in_ready;
        s = use_def ? so_def : serial_out;
        chk({tag, " ready_after"}, {31'd0, r}, 32'd1);
        chk({tag, " idle_line"}, {31'd0, s}, 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input bit hold_valid);
        data_in = d;
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold_valid) data_in_valid = 1'b0;
        chk("handshake ready_drop", {31'd0, data_in_ready}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset serial_out", {31'd0, serial_out}, 32'd1);
        chk("reset ready", {31'd0, data_in_ready}, 32'd1);
        chk("reset def serial_out", {31'd0, so_def}, 32'd1);
        chk("reset def ready", {31'd0, ready_def}, 32'd1);
        rst = 1'b0;

        // 0x55 right after reset release: accepted on the first edge.
        send(8'h55, 1'b0);
        check_frame("f55", 8'h55, 1'b0, 10);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back with valid held; data_in changes mid-frame.
        send(8'hA3, 1'b1);
        data_in = 8'h0F;
        check_frame("fA3", 8'hA3, 1'b0, 10);
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        check_frame("f0F", 8'h0F, 1'b0, 10);

        send(8'hFF, 1'b1);
        data_in = 8'h00;
        check_frame("fFF", 8'hFF, 1'b0, 10);
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        check_frame("f00", 8'h00, 1'b0, 10);
        repeat (2) @(posedge clk);
        #1;

        // Reset 35 cycles into a 0x81 frame (line is in data bit 2, low).
        send(8'h81, 1'b0);
        repeat (35) @(posedge clk);
        #1;
        chk("pre_abort line", {31'd0, serial_out}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("abort serial_out", {31'd0, serial_out}, 32'd1);
        chk("abort ready", {31'd0, data_in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("abort hold serial_out", {31'd0, serial_out}, 32'd1);
        rst = 1'b0;
        send(8'h81, 1'b0);
        check_frame("f81", 8'h81, 1'b0, 10);

        send(8'h07, 1'b0);
        check_frame("f07", 8'h07, 1'b0, 10);
        send(8'h03, 1'b0);
        check_frame("f03", 8'h03, 1'b0, 10);

        // Default rate: 434 cycles per bit.
        data_def = 8'h41;
        valid_def = 1'b1;
        @(posedge clk); #1;
        valid_def = 1'b0;
        chk("def handshake ready_drop", {31'd0, ready_def}, 32'd0);
        check_frame("def41", 8'h41, 1'b1, 434);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
